gun_input_conditioner: RTL and testbench

Multi-channel light-gun front end. It sits between the raw gun pins (trigger, photodetector) and game logic in top_DH, replacing direct use of the unconditioned pins. Per channel it synchronises and debounces the trigger and emits a one-cycle press pulse. It then runs a shot sequence: request a target flash, sample the photodetector in a window, and report hit or miss. Channel count, debounce length, polarity and shot timing are all parameters.

---
 rtl/gun_input_conditioner.sv | 157 +++++++++++++++
 tb/tb_gun_input_conditioner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gun_input_conditioner.sv
// rtl/gun_input_conditioner.sv - per-channel light-gun trigger debounce and shot sequencer
module gun_input_conditioner #(
  parameter int N_GUNS           = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 650000,
  parameter int FLASH_DELAY      = 16,
  parameter int WINDOW_CYCLES    = 1088000,
  parameter bit TRIG_ACTIVE_LOW  = 1'b0,
  parameter bit PHOTO_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_GUNS-1:0] trigger_raw,
  input  logic [N_GUNS-1:0] photo_raw,
  output logic [N_GUNS-1:0] trigger_level,
  output logic [N_GUNS-1:0] trigger_pulse,
  output logic [N_GUNS-1:0] flash_req,
  output logic [N_GUNS-1:0] busy,
  output logic [N_GUNS-1:0] shot_valid,
  output logic [N_GUNS-1:0] shot_hit
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_MAX = (FLASH_DELAY > WINDOW_CYCLES) ? FLASH_DELAY : WINDOW_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  ARM_LAST   = PH_W'(FLASH_DELAY - 1);
  localparam logic [PH_W-1:0]  WIN_LAST   = PH_W'(WINDOW_CYCLES - 1);
  localparam logic             TRIG_IDLE  = TRIG_ACTIVE_LOW;
  localparam logic             PHOTO_IDLE = PHOTO_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    SAMPLE  = 3'd2,
    REPORT  = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  for (genvar g = 0; g < N_GUNS; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] trig_sync;
    logic [SYNC_STAGES-1:0] photo_sync;
    logic                   s_trig;
    logic                   s_photo;
    logic [CNT_W-1:0]       db_cnt;
    logic                   level;
    logic                   pulse;
    state_t                 state;
    logic [PH_W-1:0]        phase;
    logic                   hit;
    logic                   flash;
    logic                   active;
    logic                   valid;
    logic                   result;

    // Sync flops reset to the pin's idle level so no false edge follows reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        trig_sync  <= {SYNC_STAGES{TRIG_IDLE}};
        photo_sync <= {SYNC_STAGES{PHOTO_IDLE}};
      end else begin
        trig_sync  <= {trig_sync[SYNC_STAGES-2:0], trigger_raw[g]};
        photo_sync <= {photo_sync[SYNC_STAGES-2:0], photo_raw[g]};
      end
    end

    assign s_trig  = trig_sync[SYNC_STAGES-1] ^ TRIG_IDLE;
    assign s_photo = photo_sync[SYNC_STAGES-1] ^ PHOTO_IDLE;

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt <= '0;
        level  <= 1'b0;
        pulse  <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (s_trig == level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt <= '0;
          level  <= ~level;
          pulse  <= ~level;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end
    end

    // Only IDLE reacts to a press; presses elsewhere are reported but ignored.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        phase  <= '0;
        hit    <= 1'b0;
        flash  <= 1'b0;
        active <= 1'b0;
        valid  <= 1'b0;
        result <= 1'b0;
      end else begin
        valid <= 1'b0;
        case (state)
          IDLE: begin
            if (pulse) begin
              state  <= ARMED;
              phase  <= '0;
              hit    <= 1'b0;
              flash  <= 1'b1;
              active <= 1'b1;
            end
          end
          ARMED: begin
            if (phase == ARM_LAST) begin
              state <= SAMPLE;
              phase <= '0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
          SAMPLE: begin
            if (s_photo) hit <= 1'b1;
            if (phase == WIN_LAST) begin
              state  <= REPORT;
              phase  <= '0;
              flash  <= 1'b0;
              valid  <= 1'b1;
              result <= hit | s_photo;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
          REPORT: begin
            state <= HOLDOFF;
          end
          HOLDOFF: begin
            if (!level) begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            flash  <= 1'b0;
            active <= 1'b0;
          end
        endcase
      end
    end

    assign trigger_level[g] = level;
    assign trigger_pulse[g] = pulse;
    assign flash_req[g]     = flash;
    assign busy[g]          = active;
    assign shot_valid[g]    = valid;
    assign shot_hit[g]      = result;
  end

endmodule

// File: tb/tb_gun_input_conditioner.sv
// tb/tb_gun_input_conditioner.sv - directed-vector bench for gun_input_conditioner
module tb_gun_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] trig_a, photo_a, trig_b, photo_b;
  logic [1:0] lev_a, pul_a, fl_a, bsy_a, sv_a, hit_a;
  logic [1:0] lev_b, pul_b, fl_b, bsy_b, sv_b, hit_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gun_input_conditioner #(
    .N_GUNS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .FLASH_DELAY(3),
    .WINDOW_CYCLES(5), .TRIG_ACTIVE_LOW(1'b0), .PHOTO_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .trigger_raw(trig_a), .photo_raw(photo_a),
    .trigger_level(lev_a), .trigger_pulse(pul_a), .flash_req(fl_a),
    .busy(bsy_a), .shot_valid(sv_a), .shot_hit(hit_a)
  );

  gun_input_conditioner #(
    .N_GUNS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .FLASH_DELAY(3),
    .WINDOW_CYCLES(5), .TRIG_ACTIVE_LOW(1'b1), .PHOTO_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .trigger_raw(trig_b), .photo_raw(photo_b),
    .trigger_level(lev_b), .trigger_pulse(pul_b), .flash_req(fl_b),
    .busy(bsy_b), .shot_valid(sv_b), .shot_hit(hit_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Trigger ch0 high for cycles 0..19; photo ch0 follows pat bit per cycle.
  task automatic shot_a(input string tn, input logic [39:0] pat, input logic exp_hit, input logic full);
    int n_sv = 0;
    logic ch1_any = 1'b0;
    for (int c = 0; c < 40; c++) begin
      trig_a  = {1'b0, c < 20};
      photo_a = {1'b0, pat[c]};
      @(negedge clk);
      n_sv += int'(sv_a[0]);
      ch1_any |= lev_a[1] | pul_a[1] | fl_a[1] | bsy_a[1] | sv_a[1];
      if (full) begin
        check($sformatf("%s_lev_c%0d", tn, c), lev_a[0], (c >= 6 && c < 26));
        check($sformatf("%s_pul_c%0d", tn, c), pul_a[0], (c == 6));
        check($sformatf("%s_fl_c%0d", tn, c), fl_a[0], (c >= 7 && c <= 14));
        check($sformatf("%s_bsy_c%0d", tn, c), bsy_a[0], (c >= 7 && c <= 26));
        check($sformatf("%s_sv_c%0d", tn, c), sv_a[0], (c == 15));
      end else if (c == 15) begin
        check({tn, "_sv15"}, sv_a[0], 1);
      end
      if (c == 15) check({tn, "_hit15"}, hit_a[0], exp_hit);
      if (c == 35) check({tn, "_hit_held"}, hit_a[0], exp_hit);
      @(posedge clk); #1;
    end
    check({tn, "_sv_count"}, n_sv, 1);
    check({tn, "_ch1_quiet"}, ch1_any, 0);
  endtask

  initial begin
    rst = 1'b1;
    trig_a = 2'b00; photo_a = 2'b00;
    trig_b = 2'b11; photo_b = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_outs", {lev_a, pul_a, fl_a, bsy_a, sv_a, hit_a}, 0);
    check("rst_b_outs", {lev_b, pul_b, fl_b, bsy_b, sv_b, hit_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("idle_b_level", lev_b, 0);

    begin : t1_bounce
      logic any_act = 1'b0;
      for (int c = 0; c < 30; c++) begin
        trig_a = {1'b0, (c < 15) && (c % 5 < 3)};
        @(negedge clk);
        any_act |= lev_a[0] | pul_a[0] | fl_a[0] | bsy_a[0];
        @(posedge clk); #1;
      end
      check("t1_bounce_quiet", any_act, 0);
    end

    shot_a("t2", 40'd0, 1'b0, 1'b1);
    shot_a("t3a", 40'd1 << 8, 1'b1, 1'b0);

    begin : t5_reset
      int n_sv = 0;
      for (int c = 0; c < 40; c++) begin
        trig_a  = {1'b0, c < 11};
        photo_a = {1'b0, (c >= 7 && c < 12)};
        rst     = (c == 11);
        @(negedge clk);
        n_sv += int'(sv_a[0]);
        if (c == 10) check("t5_inflight", fl_a[0], 1);
        if (c == 12) check("t5_outs_zero", {lev_a, pul_a, fl_a, bsy_a, sv_a, hit_a}, 0);
        @(posedge clk); #1;
      end
      check("t5_no_sv", n_sv, 0);
    end
    shot_a("t5b", 40'd0, 1'b0, 1'b1);

    shot_a("t3b", (40'd7 << 5) | (40'd1 << 13), 1'b0, 1'b0);

    begin : t4a_hold
      int n_sv = 0;
      int n_pul = 0;
      for (int c = 0; c < 115; c++) begin
        trig_a  = {1'b0, c < 100};
        photo_a = 2'b00;
        @(negedge clk);
        n_sv  += int'(sv_a[0]);
        n_pul += int'(pul_a[0]);
        if (c == 15)  check("t4a_sv15", sv_a[0], 1);
        if (c == 60)  check("t4a_busy60", bsy_a[0], 1);
        if (c == 106) check("t4a_busy106", bsy_a[0], 1);
        if (c == 107) check("t4a_busy107", bsy_a[0], 0);
        @(posedge clk); #1;
      end
      check("t4a_sv_count", n_sv, 1);
      check("t4a_pul_count", n_pul, 1);
    end

    begin : t4b_repress
      int n_sv = 0;
      int n_pul = 0;
      for (int c = 0; c < 45; c++) begin
        trig_a = {1'b0, (c < 4) || (c >= 8 && c < 30)};
        @(negedge clk);
        n_sv  += int'(sv_a[0]);
        n_pul += int'(pul_a[0]);
        if (c == 14) check("t4b_pul14", pul_a[0], 1);
        if (c == 15) check("t4b_sv15", sv_a[0], 1);
        if (c == 16) check("t4b_fl16", fl_a[0], 0);
        if (c == 36) check("t4b_busy36", bsy_a[0], 1);
        if (c == 37) check("t4b_busy37", bsy_a[0], 0);
        @(posedge clk); #1;
      end
      check("t4b_sv_count", n_sv, 1);
      check("t4b_pul_count", n_pul, 2);
    end
    shot_a("t4c", 40'd0, 1'b0, 1'b0);

    begin : t6_indep
      int n0 = 0;
      int n1 = 0;
      for (int c = 0; c < 45; c++) begin
        trig_a  = 2'b00;
        photo_a = 2'b00;
        trig_b  = {!(c >= 3 && c < 33), !(c < 30)};
        photo_b = {1'b0, c == 11};
        @(negedge clk);
        n0 += int'(sv_b[0]);
        n1 += int'(sv_b[1]);
        if (c == 8)  check("t6_fl1_c8", fl_b[1], 0);
        if (c == 10) check("t6_fl1_c10", fl_b[1], 1);
        if (c == 15) begin
          check("t6_sv0_15", sv_b[0], 1);
          check("t6_hit0_15", hit_b[0], 1);
          check("t6_sv1_15", sv_b[1], 0);
        end
        if (c == 18) begin
          check("t6_sv1_18", sv_b[1], 1);
          check("t6_hit1_18", hit_b[1], 0);
        end
        @(posedge clk); #1;
      end
      check("t6_sv0_count", n0, 1);
      check("t6_sv1_count", n1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
